// File: rtl/vj_sched_pkg.sv
// Shared types and default pyramid geometry for the VJ window scheduler.
package vj_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int COORD_W      = 32;
  localparam int LEVEL_W_BITS = 4;
  localparam int WIN          = 24;
  localparam int MAX_LEVELS   = 16;

  localparam int LAPTOP_HEIGHT = 480;
  localparam int LAPTOP_WIDTH  = 640;

  // Pyramid scale of 1.25: each level shrinks by 4/5 (integer floor).
  localparam int SCALE_NUM = 4;
  localparam int SCALE_DEN = 5;

  typedef logic [MAX_LEVELS-1:0][COORD_W-1:0] level_tbl_t;

  function automatic level_tbl_t pyramid_tbl(input int base);
    level_tbl_t t;
    int         v;
    v = base;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      t[i] = 32'(v);
      v    = v * SCALE_NUM / SCALE_DEN;
    end
    return t;
  endfunction

  localparam level_tbl_t DEF_LEVEL_H = pyramid_tbl(LAPTOP_HEIGHT);
  localparam level_tbl_t DEF_LEVEL_W = pyramid_tbl(LAPTOP_WIDTH);

endpackage

// File: rtl/vj_scan_scheduler.sv
// Walks every WINxWIN window of every pyramid level, issues them to the VJ
// pipeline under an in-flight cap, forwards face hits and flags frame done.
module vj_scan_scheduler
  import vj_sched_pkg::*;
#(
  parameter int         NUM_LEVELS   = 10,
  parameter int         WIN          = vj_sched_pkg::WIN,
  parameter int         MAX_INFLIGHT = 32,
  parameter level_tbl_t LEVEL_H      = DEF_LEVEL_H,
  parameter level_tbl_t LEVEL_W      = DEF_LEVEL_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    img_rdy,
  output logic                    busy,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [3:0]              win_level,
  output logic [31:0]             win_row,
  output logic [31:0]             win_col,
  input  logic                    res_valid,
  input  logic                    res_face,
  input  logic [3:0]              res_level,
  input  logic [31:0]             res_row,
  input  logic [31:0]             res_col,
  output logic [1:0][31:0]        face_coords,
  output logic                    face_coords_ready,
  output logic [3:0]              pyramid_number,
  output logic                    vj_pipeline_done
);

  localparam int                   CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [COORD_W-1:0]   WIN_C = COORD_W'(WIN);
  localparam logic [CNT_W-1:0]     MAX_C = CNT_W'(MAX_INFLIGHT);
  localparam logic [LEVEL_W_BITS-1:0] LAST_LVL = LEVEL_W_BITS'(NUM_LEVELS - 1);

  state_t                    r_state;
  logic [LEVEL_W_BITS-1:0]   r_level;
  logic [COORD_W-1:0]        r_row;
  logic [COORD_W-1:0]        r_col;
  logic [CNT_W-1:0]          r_inflight;
  logic                      r_face_rdy;
  logic [1:0][COORD_W-1:0]   r_face;
  logic [LEVEL_W_BITS-1:0]   r_pyr;

  logic [COORD_W-1:0]        w_h;
  logic [COORD_W-1:0]        w_w;
  logic [COORD_W-1:0]        w_row_last;
  logic [COORD_W-1:0]        w_col_last;
  logic                      w_fits;
  logic                      w_last_lvl;
  logic                      w_fire;
  logic                      w_dec;

  assign w_h        = LEVEL_H[r_level];
  assign w_w        = LEVEL_W[r_level];
  assign w_fits     = (w_h >= WIN_C) && (w_w >= WIN_C);
  assign w_row_last = w_h - WIN_C;
  assign w_col_last = w_w - WIN_C;
  assign w_last_lvl = (r_level == LAST_LVL);

  // Issue is gated purely by registered state, so coordinates and valid are
  // stable for the whole cycle regardless of the pipeline's ready.
  assign win_valid  = (r_state == S_SCAN) && (r_inflight < MAX_C);
  assign w_fire     = win_valid && win_ready;
  // A result with nothing outstanding is a stray and must not underflow.
  assign w_dec      = res_valid && (r_inflight != '0);

  assign busy              = (r_state != S_IDLE);
  assign vj_pipeline_done  = (r_state == S_DONE);
  assign win_level         = r_level;
  assign win_row           = r_row;
  assign win_col           = r_col;
  assign face_coords       = r_face;
  assign face_coords_ready = r_face_rdy;
  assign pyramid_number    = r_pyr;

  // Frame sequencer: level setup, raster walk of windows, drain, done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (img_rdy) begin
          r_level <= '0;
          r_row   <= '0;
          r_col   <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_fits)          r_state <= S_SCAN;
          else if (w_last_lvl) r_state <= S_DRAIN;
          else                 r_level <= r_level + 1'b1;
        end
        S_SCAN: if (w_fire) begin
          if (r_col == w_col_last) begin
            r_col <= '0;
            if (r_row == w_row_last) begin
              r_row <= '0;
              if (w_last_lvl) begin
                r_state <= S_DRAIN;
              end else begin
                r_level <= r_level + 1'b1;
                r_state <= S_LOAD;
              end
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DRAIN: if (r_inflight == '0) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outstanding-window count; a simultaneous fire and result cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_inflight <= '0;
    else if (w_fire && !w_dec) r_inflight <= r_inflight + 1'b1;
    else if (w_dec && !w_fire) r_inflight <= r_inflight - 1'b1;
  end

  // Register each face hit's tag and strobe it for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_face_rdy <= 1'b0;
      r_face     <= '0;
      r_pyr      <= '0;
    end else begin
      r_face_rdy <= res_valid && res_face;
      if (res_valid && res_face) begin
        r_face[0] <= res_row;
        r_face[1] <= res_col;
        r_pyr     <= res_level;
      end
    end
  end

endmodule

// File: tb/tb_vj_scan_scheduler.sv
// Directed bench for vj_scan_scheduler on a tiny two-level frame
// (L0 26x25 -> 3x2 windows, L1 20x20 -> no windows) with a cap of 4.
module tb_vj_scan_scheduler;

  localparam vj_sched_pkg::level_tbl_t TB_H = {448'd0, 32'd20, 32'd26};
  localparam vj_sched_pkg::level_tbl_t TB_W = {448'd0, 32'd20, 32'd25};

  logic             clock, reset, img_rdy, busy, win_valid, win_ready;
  logic [3:0]       win_level, res_level, pyramid_number;
  logic [31:0]      win_row, win_col, res_row, res_col;
  logic             res_valid, res_face, face_coords_ready, vj_pipeline_done;
  logic [1:0][31:0] face_coords;

  int checks = 0;
  int errors = 0;

  vj_scan_scheduler #(
    .NUM_LEVELS(2), .WIN(24), .MAX_INFLIGHT(4), .LEVEL_H(TB_H), .LEVEL_W(TB_W)
  ) dut (
    .clock(clock), .reset(reset), .img_rdy(img_rdy), .busy(busy),
    .win_valid(win_valid), .win_ready(win_ready), .win_level(win_level),
    .win_row(win_row), .win_col(win_col), .res_valid(res_valid),
    .res_face(res_face), .res_level(res_level), .res_row(res_row),
    .res_col(res_col), .face_coords(face_coords),
    .face_coords_ready(face_coords_ready), .pyramid_number(pyramid_number),
    .vj_pipeline_done(vj_pipeline_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; img_rdy = 0; win_ready = 0; res_valid = 0; res_face = 0;
    res_level = 0; res_row = 0; res_col = 0;
    step(); step();
    checks++;
    if ({busy, win_valid, face_coords_ready, vj_pipeline_done} !== 4'b0 ||
        face_coords !== '0 || pyramid_number !== 0 ||
        win_level !== 0 || win_row !== 0 || win_col !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b vld=%b frdy=%b done=%b fc=%h pyr=%0d win=(%0d,%0d,%0d) want all 0",
               busy, win_valid, face_coords_ready, vj_pipeline_done, face_coords,
               pyramid_number, win_level, win_row, win_col);
    end
    reset = 1'b0;
    step();
  endtask

  // Full frame, ready held high, each result returned 3 cycles after its fire.
  task automatic test_tiny_frame(input string tag);
    int fired = 0, dones = 0, first_v = -1, done_cyc = -1;
    logic [2:0] hist = '0;
    win_ready = 1; res_face = 0; res_valid = 0;
    img_rdy = 1; step(); img_rdy = 0;
    checks++;
    if (busy !== 1 || win_valid !== 0) begin
      errors++;
      $display("FAIL %s_load: busy=%b vld=%b want busy=1 vld=0", tag, busy, win_valid);
    end
    for (int cyc = 1; cyc < 40 && dones == 0; cyc++) begin
      res_valid = hist[2];
      if (win_valid) begin
        if (first_v < 0) first_v = cyc;
        checks++;
        if (win_level !== 0 || win_row !== 32'(fired >> 1) || win_col !== 32'(fired & 1)) begin
          errors++;
          $display("FAIL %s_order: win#%0d got (%0d,%0d,%0d) want (0,%0d,%0d)",
                   tag, fired, win_level, win_row, win_col, fired >> 1, fired & 1);
        end
        fired++;
      end
      hist = {hist[1:0], win_valid};
      step();
      if (vj_pipeline_done) begin dones++; done_cyc = cyc + 1; end
    end
    res_valid = 0;
    checks++;
    if (fired != 6 || first_v != 2 || done_cyc != 12) begin
      errors++;
      $display("FAIL %s_timing: fired=%0d first_vld=%0d done_cyc=%0d want 6/2/12",
               tag, fired, first_v, done_cyc);
    end
    step();
    checks++;
    if (busy !== 0 || vj_pipeline_done !== 0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b want 0/0", tag, busy, vj_pipeline_done);
    end
  endtask

  task automatic test_face_hits();
    logic [3:0]  lv [3] = '{4'd1, 4'd1, 4'd2};
    logic [31:0] rw [3] = '{32'd10, 32'd10, 32'd0};
    logic [31:0] cl [3] = '{32'd7, 32'd8, 32'd0};
    res_face = 1;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1; res_level = lv[i]; res_row = rw[i]; res_col = cl[i];
      step();
      checks++;
      if (face_coords_ready !== 1 || pyramid_number !== lv[i] ||
          face_coords[0] !== rw[i] || face_coords[1] !== cl[i]) begin
        errors++;
        $display("FAIL face_hit%0d: rdy=%b (%0d,%0d,%0d) want rdy=1 (%0d,%0d,%0d)", i,
                 face_coords_ready, pyramid_number, face_coords[0], face_coords[1],
                 lv[i], rw[i], cl[i]);
      end
    end
    res_face = 0; res_level = 5; res_row = 9; res_col = 9;
    step();
    res_valid = 0;
    checks++;
    if (face_coords_ready !== 0 || pyramid_number !== 2 || face_coords !== '0) begin
      errors++;
      $display("FAIL face_nonhit: rdy=%b pyr=%0d fc=%h want rdy=0 pyr=2 fc=0",
               face_coords_ready, pyramid_number, face_coords);
    end
  endtask

  task automatic test_backpressure();
    int fired = 0, dones = 0;
    logic [2:0] hist = '0;
    logic stalled = 0;
    logic [3:0] s_lv = 0; logic [31:0] s_rw = 0, s_cl = 0;
    logic fire;
    res_face = 0; res_valid = 0; win_ready = 0;
    img_rdy = 1; step(); img_rdy = 0;
    for (int cyc = 1; cyc < 300 && dones == 0; cyc++) begin
      win_ready = 1'($urandom_range(0, 1));
      res_valid = hist[2];
      if (win_valid && stalled) begin
        checks++;
        if (win_level !== s_lv || win_row !== s_rw || win_col !== s_cl) begin
          errors++;
          $display("FAIL bp_hold: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   win_level, win_row, win_col, s_lv, s_rw, s_cl);
        end
      end
      fire = win_valid && win_ready;
      if (fire) begin
        checks++;
        if (win_level !== 0 || win_row !== 32'(fired >> 1) || win_col !== 32'(fired & 1)) begin
          errors++;
          $display("FAIL bp_order: win#%0d got (%0d,%0d,%0d) want (0,%0d,%0d)",
                   fired, win_level, win_row, win_col, fired >> 1, fired & 1);
        end
        fired++;
      end
      stalled = win_valid && !win_ready;
      s_lv = win_level; s_rw = win_row; s_cl = win_col;
      hist = {hist[1:0], fire};
      step();
      if (vj_pipeline_done) dones++;
    end
    res_valid = 0; win_ready = 1;
    checks++;
    if (fired != 6 || dones != 1) begin
      errors++;
      $display("FAIL bp_count: fired=%0d dones=%0d want 6/1", fired, dones);
    end
    step();
  endtask

  task automatic test_inflight_cap();
    win_ready = 1; res_valid = 0; res_face = 0;
    img_rdy = 1; step(); img_rdy = 0;  // cycle 1
    step();                            // cycle 2
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (win_valid !== 1) begin
        errors++;
        $display("FAIL cap_fill%0d: vld=%b want 1", k, win_valid);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin   // cycles 6,7: capped
      checks++;
      if (win_valid !== 0) begin
        errors++;
        $display("FAIL cap_block%0d: vld=%b want 0", k, win_valid);
      end
      if (k == 1) res_valid = 1;
      step();
    end
    // cycle 8: one result freed a slot; fire and result together
    checks++;
    if (win_valid !== 1 || win_row !== 2 || win_col !== 0) begin
      errors++;
      $display("FAIL cap_reopen: vld=%b (%0d,%0d) want vld=1 (2,0)", win_valid, win_row, win_col);
    end
    step();
    res_valid = 0;
    // cycle 9: count must still be 3, so issue continues
    checks++;
    if (win_valid !== 1 || win_row !== 2 || win_col !== 1) begin
      errors++;
      $display("FAIL cap_same_cycle: vld=%b (%0d,%0d) want vld=1 (2,1)", win_valid, win_row, win_col);
    end
    step(); step(); step();              // LOAD, DRAIN, cycle 12
    for (int k = 0; k < 3; k++) begin res_valid = 1; step(); end
    res_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vj_pipeline_done !== 0 || busy !== 1) begin
        errors++;
        $display("FAIL cap_drain%0d: done=%b busy=%b want 0/1", k, vj_pipeline_done, busy);
      end
      step();
    end
    res_valid = 1; step(); res_valid = 0;
    checks++;
    if (vj_pipeline_done !== 0) begin
      errors++;
      $display("FAIL cap_done_early: done=%b want 0", vj_pipeline_done);
    end
    step();
    checks++;
    if (vj_pipeline_done !== 1) begin
      errors++;
      $display("FAIL cap_done: done=%b want 1", vj_pipeline_done);
    end
    step();
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL cap_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    win_ready = 1; res_face = 0;
    res_valid = 1; step(); step(); step(); res_valid = 0;
    checks++;
    if (busy !== 0 || face_coords_ready !== 0) begin
      errors++;
      $display("FAIL stray_idle: busy=%b frdy=%b want 0/0", busy, face_coords_ready);
    end
    img_rdy = 1; step(); img_rdy = 0;  // cycle 1
    step();                            // cycle 2
    checks++;
    if (win_valid !== 1 || win_row !== 0 || win_col !== 0) begin
      errors++;
      $display("FAIL stray_inflight: vld=%b (%0d,%0d) want vld=1 (0,0)", win_valid, win_row, win_col);
    end
    img_rdy = 1; step(); img_rdy = 0;  // cycle 3, start pulse during SCAN
    step();                            // cycle 4
    checks++;
    if (win_valid !== 1 || win_row !== 1 || win_col !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL start_ignored: vld=%b busy=%b (%0d,%0d) want 1/1 (1,0)",
               win_valid, busy, win_row, win_col);
    end
  endtask

  // Continues from the SCAN state left by test_start_while_busy.
  task automatic test_reset_mid_scan();
    int dones = 0;
    win_ready = 0;
    res_valid = 1; res_face = 1; res_level = 3; res_row = 5; res_col = 6;
    step();
    res_valid = 0; res_face = 0;
    checks++;
    if (face_coords_ready !== 1 || face_coords[0] !== 5 || face_coords[1] !== 6 || pyramid_number !== 3) begin
      errors++;
      $display("FAIL pre_reset_hit: rdy=%b (%0d,%0d,%0d) want 1 (3,5,6)",
               face_coords_ready, pyramid_number, face_coords[0], face_coords[1]);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({busy, win_valid, face_coords_ready, vj_pipeline_done} !== 4'b0 ||
        face_coords !== '0 || pyramid_number !== 0 ||
        win_level !== 0 || win_row !== 0 || win_col !== 0) begin
      errors++;
      $display("FAIL async_reset: busy=%b vld=%b frdy=%b done=%b fc=%h pyr=%0d win=(%0d,%0d,%0d) want all 0",
               busy, win_valid, face_coords_ready, vj_pipeline_done, face_coords,
               pyramid_number, win_level, win_row, win_col);
    end
    step(); step();
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (vj_pipeline_done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d busy=%b want 0/0", dones, busy);
    end
    test_tiny_frame("after_reset");
  endtask

  initial begin
    test_reset();
    test_tiny_frame("tiny");
    test_face_hits();
    test_backpressure();
    test_inflight_cap();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
